uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one `uart` MMIO slot's TX path between NUM_REQ byte producers.
- After reset, configures the divisor register (0x08) once.
- Then round-robin accepts bytes from requesters. For each byte it polls the status register (0x10) until TX FIFO is not full, then writes the byte to 0x04.
- Sits between on-chip producers (debug console, log engine) and the uart slot interface, as that slot's only master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, byte width; must match the uart's DATA_BITS.
- DVSR_WIDTH, 10, divisor width.
- DVSR_INIT, 10'd325, divisor written at start-up.
- MAX_RETRY, 4, consecutive rejected TX writes before the byte is dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  NUM_REQ*DATA_BITS  byte of requester i at bits [i*DATA_BITS +: DATA_BITS]
- req_ready  out  NUM_REQ  one-hot accept pulse
- slot_cs  out  1  uart chip_select
- slot_read  out  1  uart read
- slot_write  out  1  uart write
- slot_addr  out  8  uart addr
- slot_wr_data  out  32  uart wr_data
- slot_done  out  1  uart transaction_completed
- slot_rd_data  in  32  uart rd_data
- slot_rd_done  in  1  uart rd_done
- slot_wr_done  in  1  uart wr_done
- slot_slave_error  in  1  uart slave_error
- slot_decode_error  in  1  uart decode_error
- busy  out  1  not in IDLE
- cfg_done  out  1  divisor write completed
- drop_err  out  1  sticky: a byte was dropped after MAX_RETRY rejected writes
- dec_err  out  1  sticky: slot_decode_error was seen with a done strobe
- bytes_sent  out  16  count of successful TX writes, wraps at 2^16

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to CFG; rr pointer = 0.
  - All outputs 0, including slot_* outputs, busy, cfg_done, drop_err, dec_err and bytes_sent.
  - Reset mid-transaction abandons the transaction with no completion pulse. The uart shares this reset.
- Slot transaction rules:
  - While in a request state, hold slot_cs=1, slot_read or slot_write, slot_addr and slot_wr_data stable until the matching done strobe (slot_rd_done / slot_wr_done) is sampled high.
  - Then enter FIN for exactly one cycle: slot_cs/read/write=0, slot_done=1.
  - FIN then goes to the latched target state.
  - Minimum of 3 cycles from request to done, given uart slot timing.
- States:
  - CFG: write addr 0x08, data zero-extended DVSR_INIT. On slot_wr_done, set cfg_done=1 and go FIN→IDLE. cfg_done stays 1 until reset.
  - IDLE: busy=0. If any req_valid, pick the first set bit searching from rr pointer upward, with wrap.
    - Pulse req_ready for the granted requester that same cycle and latch its byte.
    - Reset retry count to 0 and go to STAT.
    - No req_valid: stay in IDLE.
  - STAT: read addr 0x10. On slot_rd_done:
    - slot_rd_data[3]==0 (TX FIFO not full): FIN→PUSH.
    - Otherwise: FIN→STAT. Polling repeats indefinitely.
  - PUSH: write addr 0x04, data = latched byte zero-extended. On slot_wr_done:
    - slot_slave_error==0: bytes_sent+1, rr pointer = granted+1 mod NUM_REQ, FIN→IDLE.
    - slot_slave_error==1 and retry count < MAX_RETRY−1: retry count+1, FIN→STAT.
    - Otherwise: set drop_err, advance rr pointer, FIN→IDLE.
- Any done strobe with slot_decode_error=1 sets dec_err. The FSM still proceeds as above.
- Fairness: the rr pointer advances only when a byte is sent or dropped.
- A requester's data need be held only while req_valid is high and before its req_ready pulse.
- The byte is latched at accept, so later req_data changes have no effect.
- Requests raised during CFG are not accepted until cfg_done=1.

Test Plan:
- Reset, then model a uart with 3-cycle response → first transaction is write 0x08 with data 325; cfg_done rises in the FIN cycle; slot_done high for exactly 1 cycle.
- req_valid=4'b1111 with data 0xA0..0xA3, status bit3=0 always → 0x04 writes in order A0, A1, A2, A3; one req_ready pulse each; bytes_sent=4.
- Status returns bit3=1 for 5 reads, then 0 → 6 status reads, then one 0x04 write; no drop_err.
- PUSH answered with slave_error on every attempt (MAX_RETRY=4) → exactly 4 writes, drop_err=1, bytes_sent unchanged, next requester served.
- Only requester 2 valid continuously while requester 0 is raised after its first grant → grants alternate 2, 0, 2, 0.
- Assert rst during a PUSH wait → all outputs 0 next cycle; CFG write is reissued.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart slot TX path between byte producers
module uart_tx_arbiter #(
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_BITS  = 8,
    parameter int                    DVSR_WIDTH = 10,
    parameter logic [DVSR_WIDTH-1:0] DVSR_INIT  = 10'd325,
    parameter int                    MAX_RETRY  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         slot_cs,
    output logic                         slot_read,
    output logic                         slot_write,
    output logic [7:0]                   slot_addr,
    output logic [31:0]                  slot_wr_data,
    output logic                         slot_done,
    input  logic [31:0]                  slot_rd_data,
    input  logic                         slot_rd_done,
    input  logic                         slot_wr_done,
    input  logic                         slot_slave_error,
    input  logic                         slot_decode_error,
    output logic                         busy,
    output logic                         cfg_done,
    output logic                         drop_err,
    output logic                         dec_err,
    output logic [15:0]                  bytes_sent
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [7:0] ADDR_TX   = 8'h04;
    localparam logic [7:0] ADDR_DVSR = 8'h08;
    localparam logic [7:0] ADDR_STAT = 8'h10;

    typedef enum logic [2:0] {S_CFG, S_IDLE, S_STAT, S_PUSH, S_FIN} state_t;

    state_t               state;
    state_t               target;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant_q;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        rr_next;
    logic                 grant_found;
    logic [DATA_BITS-1:0] byte_q;
    logic [RW-1:0]        retry_cnt;
    int                   cand;

    // Only the TX-full flag of the status word matters here.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{slot_rd_data[31:4], slot_rd_data[2:0]};

    // After a byte is sent or dropped, the search starts just past its owner.
    assign rr_next = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // First valid requester at or above the rr pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    // Accept pulse coincides with the IDLE cycle that latches the byte.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Main FSM: each slot request is held until its done strobe, then one FIN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_CFG;
            target       <= S_IDLE;
            rr_ptr       <= '0;
            grant_q      <= '0;
            byte_q       <= '0;
            retry_cnt    <= '0;
            slot_cs      <= 1'b0;
            slot_read    <= 1'b0;
            slot_write   <= 1'b0;
            slot_addr    <= '0;
            slot_wr_data <= '0;
            slot_done    <= 1'b0;
            busy         <= 1'b0;
            cfg_done     <= 1'b0;
            drop_err     <= 1'b0;
            dec_err      <= 1'b0;
            bytes_sent   <= '0;
        end else begin
            slot_done <= 1'b0;
            if ((slot_rd_done || slot_wr_done) && slot_decode_error) begin
                dec_err <= 1'b1;
            end
            case (state)
                S_CFG: begin
                    if (slot_cs && slot_wr_done) begin
                        cfg_done   <= 1'b1;
                        target     <= S_IDLE;
                        slot_cs    <= 1'b0;
                        slot_write <= 1'b0;
                        slot_done  <= 1'b1;
                        state      <= S_FIN;
                    end else begin
                        busy         <= 1'b1;
                        slot_cs      <= 1'b1;
                        slot_write   <= 1'b1;
                        slot_addr    <= ADDR_DVSR;
                        slot_wr_data <= 32'(DVSR_INIT);
                    end
                end
                S_IDLE: begin
                    if (grant_found) begin
                        grant_q      <= grant_idx;
                        byte_q       <= req_data[grant_idx*DATA_BITS +: DATA_BITS];
                        retry_cnt    <= '0;
                        busy         <= 1'b1;
                        slot_cs      <= 1'b1;
                        slot_read    <= 1'b1;
                        slot_addr    <= ADDR_STAT;
                        slot_wr_data <= '0;
                        state        <= S_STAT;
                    end
                end
                S_STAT: begin
                    if (slot_rd_done) begin
                        target    <= slot_rd_data[3] ? S_STAT : S_PUSH;
                        slot_cs   <= 1'b0;
                        slot_read <= 1'b0;
                        slot_done <= 1'b1;
                        state     <= S_FIN;
                    end
                end
                S_PUSH: begin
                    if (slot_wr_done) begin
                        if (!slot_slave_error) begin
                            bytes_sent <= bytes_sent + 16'd1;
                            rr_ptr     <= rr_next;
                            target     <= S_IDLE;
                        end else if (retry_cnt < RW'(MAX_RETRY - 1)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            target    <= S_STAT;
                        end else begin
                            drop_err <= 1'b1;
                            rr_ptr   <= rr_next;
                            target   <= S_IDLE;
                        end
                        slot_cs    <= 1'b0;
                        slot_write <= 1'b0;
                        slot_done  <= 1'b1;
                        state      <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= target;
                    busy  <= (target != S_IDLE);
                    if (target == S_STAT) begin
                        slot_cs      <= 1'b1;
                        slot_read    <= 1'b1;
                        slot_addr    <= ADDR_STAT;
                        slot_wr_data <= '0;
                    end else if (target == S_PUSH) begin
                        slot_cs      <= 1'b1;
                        slot_write   <= 1'b1;
                        slot_addr    <= ADDR_TX;
                        slot_wr_data <= 32'(byte_q);
                    end
                end
                default: state <= S_CFG;
            endcase
        end
    end
endmodule
